// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and
// the grant identifiers used by round-robin arbitration.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory bus and stall signals.
// The arbiter uses the slave view; the datapath/memory side uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_ack;

    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic [BE_W-1:0]   i_d_be;
    logic [DATA_W-1:0] o_d_rdata;
    logic              o_d_ack;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [BE_W-1:0]   o_mem_be;
    logic              i_mem_ready;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_stall;
    logic              o_bus_error;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_rdata, o_if_ack,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        output o_d_rdata, o_d_ack,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_ready, i_mem_rdata,
        output o_stall, o_bus_error
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_rdata, o_if_ack,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        input  o_d_rdata, o_d_ack,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_ready, i_mem_rdata,
        input  o_stall, o_bus_error
    );

endinterface

// File: rtl/mem_arb_timeout.sv
// Wait-state counter for a memory access: cleared at grant, counts while the
// memory is not ready, and flags done once it has reached TIMEOUT.
module mem_arb_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Clear takes priority so every access starts from zero and never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising instruction fetch and load/store traffic
// onto one wait-stated memory, with registered bus outputs and timeout abort.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    state_t state;
    grant_t last_grant;
    logic   any_req;
    logic   pick_d;
    logic   timer_clear;
    logic   timer_enable;
    logic   timer_done;

    // Data wins a tie only when fetch was served last.
    always_comb begin
        any_req      = bus.i_if_req | bus.i_d_req;
        pick_d       = bus.i_d_req & (~bus.i_if_req | (last_grant == GRANT_IF));
        timer_clear  = (state == IDLE) & any_req;
        timer_enable = (state == ACCESS) & ~bus.i_mem_ready & ~timer_done;
    end

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .done    (timer_done)
    );

    assign bus.o_stall = (bus.i_if_req & ~bus.o_if_ack) | (bus.i_d_req & ~bus.o_d_ack);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            last_grant      <= GRANT_IF;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= {ADDR_W{1'b0}};
            bus.o_mem_wdata <= {DATA_W{1'b0}};
            bus.o_mem_be    <= {BE_W{1'b0}};
            bus.o_if_rdata  <= {DATA_W{1'b0}};
            bus.o_d_rdata   <= {DATA_W{1'b0}};
            bus.o_if_ack    <= 1'b0;
            bus.o_d_ack     <= 1'b0;
            bus.o_bus_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state         <= ACCESS;
                        bus.o_mem_req <= 1'b1;
                        if (pick_d) begin
                            last_grant      <= GRANT_D;
                            bus.o_mem_we    <= bus.i_d_we;
                            bus.o_mem_addr  <= bus.i_d_addr;
                            bus.o_mem_wdata <= bus.i_d_wdata;
                            bus.o_mem_be    <= bus.i_d_be;
                        end else begin
                            last_grant      <= GRANT_IF;
                            bus.o_mem_we    <= 1'b0;
                            bus.o_mem_addr  <= bus.i_if_addr;
                            bus.o_mem_wdata <= {DATA_W{1'b0}};
                            bus.o_mem_be    <= {BE_W{1'b1}};
                        end
                    end
                end
                // Ready is checked before timeout so a last-moment response still completes.
                ACCESS: begin
                    if (bus.i_mem_ready) begin
                        state         <= RESP;
                        bus.o_mem_req <= 1'b0;
                        if (last_grant == GRANT_D) begin
                            bus.o_d_rdata <= bus.i_mem_rdata;
                            bus.o_d_ack   <= 1'b1;
                        end else begin
                            bus.o_if_rdata <= bus.i_mem_rdata;
                            bus.o_if_ack   <= 1'b1;
                        end
                    end else if (timer_done) begin
                        state           <= RESP;
                        bus.o_mem_req   <= 1'b0;
                        bus.o_bus_error <= 1'b1;
                        if (last_grant == GRANT_D) begin
                            bus.o_d_rdata <= {DATA_W{1'b0}};
                            bus.o_d_ack   <= 1'b1;
                        end else begin
                            bus.o_if_rdata <= {DATA_W{1'b0}};
                            bus.o_if_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    bus.o_if_ack    <= 1'b0;
                    bus.o_d_ack     <= 1'b0;
                    bus.o_bus_error <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency, wait states,
// round-robin order, timeout abort, async reset and ready-at-timeout race.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam logic [31:0] RD_MASK = 32'h5A5A_5A5A;

    logic clk;
    logic rst_n;
    int   check_count;
    int   error_count;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                                 input logic d_req, input logic d_we, input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata, input logic [3:0] d_be);
        bus.i_if_req  = if_req;
        bus.i_if_addr = if_addr;
        bus.i_d_req   = d_req;
        bus.i_d_we    = d_we;
        bus.i_d_addr  = d_addr;
        bus.i_d_wdata = d_wdata;
        bus.i_d_be    = d_be;
    endtask

    // Acts as the memory for one access: raises ready on the ready_at-th cycle
    // of o_mem_req (0 = never) and checks the held bus fields every such cycle.
    task automatic serve(input logic port_d, input int ready_at, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                         input int max_cycles,
                         output int req_cycles, output int ack_cycle, output logic seen,
                         output logic err, output logic [31:0] rd, output logic stall_at_ack);
        req_cycles   = 0;
        ack_cycle    = -1;
        seen         = 1'b0;
        err          = 1'b0;
        rd           = '0;
        stall_at_ack = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            bus.i_mem_ready = bus.o_mem_req && (ready_at != 0) && (req_cycles + 1 == ready_at);
            bus.i_mem_rdata = rdata;
            @(negedge clk);
            if (port_d ? bus.o_d_ack : bus.o_if_ack) begin
                seen         = 1'b1;
                ack_cycle    = c;
                err          = bus.o_bus_error;
                rd           = port_d ? bus.o_d_rdata : bus.o_if_rdata;
                stall_at_ack = bus.o_stall;
            end else if (bus.o_mem_req) begin
                req_cycles++;
                checkOutput("mem_we", {31'b0, bus.o_mem_we}, {31'b0, exp_we});
                checkOutput("mem_addr", bus.o_mem_addr, exp_addr);
                checkOutput("mem_be", {28'b0, bus.o_mem_be}, {28'b0, exp_be});
                if (exp_we) checkOutput("mem_wdata", bus.o_mem_wdata, exp_wdata);
            end
            @(posedge clk);
            #1;
        end
        bus.i_mem_ready = 1'b0;
        checkOutput("ack_seen", {31'b0, seen}, 32'd1);
    endtask

    int          req_cycles;
    int          ack_cycle;
    logic        seen;
    logic        err;
    logic [31:0] rd;
    logic        stall_at_ack;
    int          n_acks;

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = 32'h0;
        #2 rst_n = 1'b0;

        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("rst_stall_follows_req", {31'b0, bus.o_stall}, 32'd1);
        @(negedge clk);
        checkOutput("rst_mem_req", {31'b0, bus.o_mem_req}, 32'd0);
        checkOutput("rst_if_ack", {31'b0, bus.o_if_ack}, 32'd0);
        checkOutput("rst_mem_addr", bus.o_mem_addr, 32'd0);
        checkOutput("rst_mem_be", {28'b0, bus.o_mem_be}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("rst_stall_idle", {31'b0, bus.o_stall}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait fetch: ack two cycles after the request is sampled.
        applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(1'b0, 1, 32'h2010_0005, 1'b0, 32'h0040_0000, 32'h0, 4'hF, 20,
              req_cycles, ack_cycle, seen, err, rd, stall_at_ack);
        checkOutput("fetch_ack_cycle", ack_cycle, 32'd2);
        checkOutput("fetch_rdata", rd, 32'h2010_0005);
        checkOutput("fetch_no_err", {31'b0, err}, 32'd0);
        checkOutput("fetch_stall_at_ack", {31'b0, stall_at_ack}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("fetch_ack_one_cycle", {31'b0, bus.o_if_ack}, 32'd0);
        checkOutput("fetch_rdata_hold", bus.o_if_rdata, 32'h2010_0005);
        @(posedge clk);
        #1;

        // Store with three wait states.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011);
        serve(1'b1, 4, 32'h0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 20,
              req_cycles, ack_cycle, seen, err, rd, stall_at_ack);
        checkOutput("store_req_cycles", req_cycles, 32'd4);
        checkOutput("store_ack_cycle", ack_cycle, 32'd5);
        checkOutput("store_no_err", {31'b0, err}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("store_ack_once", {31'b0, bus.o_d_ack}, 32'd0);
        @(posedge clk);
        #1;

        // Both ports requesting continuously from reset: D, IF, D, IF.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 32'h0040_0100, 1'b1, 1'b0, 32'h1000_0100, 32'h0, 4'hF);
        bus.i_mem_ready = 1'b1;
        n_acks = 0;
        for (int c = 0; c < 12; c++) begin
            bus.i_mem_rdata = bus.o_mem_addr ^ RD_MASK;
            @(negedge clk);
            if (bus.o_d_ack || bus.o_if_ack) begin
                if (n_acks < 4) begin
                    checkOutput("rr_port_is_d", {31'b0, bus.o_d_ack}, (n_acks % 2 == 0) ? 32'd1 : 32'd0);
                    checkOutput("rr_rdata", bus.o_d_ack ? bus.o_d_rdata : bus.o_if_rdata,
                                ((n_acks % 2 == 0) ? 32'h1000_0100 : 32'h0040_0100) ^ RD_MASK);
                end
                n_acks++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rr_ack_count", n_acks, 32'd4);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.i_mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Memory never ready: abort after TIMEOUT+1 request cycles.
        applyStimulus(1'b1, 32'h0040_0200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(1'b0, 0, 32'h1234_5678, 1'b0, 32'h0040_0200, 32'h0, 4'hF, 40,
              req_cycles, ack_cycle, seen, err, rd, stall_at_ack);
        checkOutput("timeout_req_cycles", req_cycles, TIMEOUT + 1);
        checkOutput("timeout_bus_error", {31'b0, err}, 32'd1);
        checkOutput("timeout_rdata_zero", rd, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("timeout_err_pulse", {31'b0, bus.o_bus_error}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0040_0204, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(1'b0, 2, 32'h0BAD_C0DE, 1'b0, 32'h0040_0204, 32'h0, 4'hF, 20,
              req_cycles, ack_cycle, seen, err, rd, stall_at_ack);
        checkOutput("after_timeout_rdata", rd, 32'h0BAD_C0DE);
        checkOutput("after_timeout_no_err", {31'b0, err}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        // Reset in the 2nd wait cycle of a load; data must win again afterwards.
        applyStimulus(1'b1, 32'h0040_0300, 1'b1, 1'b0, 32'h1000_0300, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_mem_addr", bus.o_mem_addr, 32'h1000_0300);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_mem_req", {31'b0, bus.o_mem_req}, 32'd0);
        checkOutput("arst_mem_addr", bus.o_mem_addr, 32'd0);
        checkOutput("arst_mem_be", {28'b0, bus.o_mem_be}, 32'd0);
        checkOutput("arst_if_rdata", bus.o_if_rdata, 32'd0);
        checkOutput("arst_d_rdata", bus.o_d_rdata, 32'd0);
        checkOutput("arst_stall", {31'b0, bus.o_stall}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("arst_no_ack", {30'b0, bus.o_d_ack, bus.o_if_ack}, 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        serve(1'b1, 1, 32'h7777_8888, 1'b0, 32'h1000_0300, 32'h0, 4'hF, 20,
              req_cycles, ack_cycle, seen, err, rd, stall_at_ack);
        checkOutput("post_rst_d_ack_cycle", ack_cycle, 32'd2);
        checkOutput("post_rst_d_rdata", rd, 32'h7777_8888);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        // Ready on the very cycle the counter reaches TIMEOUT: normal completion.
        applyStimulus(1'b1, 32'h0040_0400, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(1'b0, TIMEOUT + 1, 32'hCAFE_F00D, 1'b0, 32'h0040_0400, 32'h0, 4'hF, 40,
              req_cycles, ack_cycle, seen, err, rd, stall_at_ack);
        checkOutput("race_req_cycles", req_cycles, TIMEOUT + 1);
        checkOutput("race_no_err", {31'b0, err}, 32'd0);
        checkOutput("race_rdata", rd, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
